mag_comparator_seq: RTL and testbench

Iterative WIDTH-bit magnitude comparator that drives the per-bit comparator slice equations nibble by nibble, MSB first, holding the equal/more/less cascade state in registers between cycles. It sits upstream of the branch-decision logic. It replaces a full-width combinational cascade with a multi-cycle start/done unit, which shortens the critical path. Signed and unsigned comparison are both supported, and the unit terminates early on the first differing nibble.

---
 rtl/mag_comparator_seq.sv | 133 +++++++++++++
 tb/tb_mag_comparator_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mag_comparator_seq.sv
// Iterative MSB-first magnitude comparator, NIB bits per cycle, signed or unsigned.
// Latency 1..WIDTH/NIB cycles (early exit on first differing nibble); start_i ignored while busy_o.
module mag_comparator_seq #(
  parameter int WIDTH = 32,
  parameter int NIB   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             a_equal_b_o,
  output logic             a_more_b_o,
  output logic             a_less_b_o
);

  localparam int NNIB = WIDTH / NIB;
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(NNIB - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             eq_q, eq_d;
  logic             more_q, more_d;
  logic             less_q, less_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             res_eq_q, res_eq_d;
  logic             res_more_q, res_more_d;
  logic             res_less_q, res_less_d;

  logic nib_eq, nib_more, nib_less;

  // Cascade of NIB comparator slices over the top nibble, seeded from the registered state.
  always_comb begin
    nib_eq   = eq_q;
    nib_more = more_q;
    nib_less = less_q;
    for (int i = 0; i < NIB; i++) begin
      nib_more = nib_more | (a_sh_q[WIDTH-1-i] & ~b_sh_q[WIDTH-1-i] & nib_eq);
      nib_less = nib_less | (~a_sh_q[WIDTH-1-i] & b_sh_q[WIDTH-1-i] & nib_eq);
      nib_eq   = nib_eq & ~(a_sh_q[WIDTH-1-i] ^ b_sh_q[WIDTH-1-i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    eq_d       = eq_q;
    more_d     = more_q;
    less_d     = less_q;
    cnt_d      = cnt_q;
    res_eq_d   = res_eq_q;
    res_more_d = res_more_q;
    res_less_d = res_less_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          // Flipping both sign bits maps two's complement onto offset binary.
          a_sh_d  = signed_i ? (a_i ^ MSB_MASK) : a_i;
          b_sh_d  = signed_i ? (b_i ^ MSB_MASK) : b_i;
          eq_d    = 1'b1;
          more_d  = 1'b0;
          less_d  = 1'b0;
          cnt_d   = CNT_LAST;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        eq_d   = nib_eq;
        more_d = nib_more;
        less_d = nib_less;
        a_sh_d = a_sh_q << NIB;
        b_sh_d = b_sh_q << NIB;
        cnt_d  = cnt_q - 1'b1;
        if (!nib_eq || (cnt_q == '0)) begin
          state_d    = DONE;
          res_eq_d   = nib_eq;
          res_more_d = nib_more;
          res_less_d = nib_less;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      eq_q       <= 1'b1;
      more_q     <= 1'b0;
      less_q     <= 1'b0;
      cnt_q      <= '0;
      res_eq_q   <= 1'b0;
      res_more_q <= 1'b0;
      res_less_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      eq_q       <= eq_d;
      more_q     <= more_d;
      less_q     <= less_d;
      cnt_q      <= cnt_d;
      res_eq_q   <= res_eq_d;
      res_more_q <= res_more_d;
      res_less_q <= res_less_d;
    end
  end

  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign a_equal_b_o = res_eq_q;
  assign a_more_b_o  = res_more_q;
  assign a_less_b_o  = res_less_q;

endmodule

// File: tb/tb_mag_comparator_seq.sv
// Self-checking bench for mag_comparator_seq: directed cases plus randomized compares
// against an arithmetic reference model.
module tb_mag_comparator_seq;

  localparam int WIDTH = 32;
  localparam int NIB   = 4;
  localparam int NNIB  = WIDTH / NIB;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic             a_equal_b_o;
  logic             a_more_b_o;
  logic             a_less_b_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mag_comparator_seq #(.WIDTH(WIDTH), .NIB(NIB)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .a_equal_b_o (a_equal_b_o),
    .a_more_b_o  (a_more_b_o),
    .a_less_b_o  (a_less_b_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected flags from plain arithmetic; k = 1-based index of first differing nibble from MSB.
  task automatic ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         output logic [2:0] flags, output int k);
    logic [WIDTH-1:0] diff;
    logic eq, more, less;
    eq = (a == b);
    if (s) begin
      more = ($signed(a) > $signed(b));
      less = ($signed(a) < $signed(b));
    end else begin
      more = (a > b);
      less = (a < b);
    end
    flags = {eq, more, less};
    k = NNIB;
    for (int n = 0; n < NNIB; n++) begin
      diff = (a ^ b) >> (WIDTH - NIB * (n + 1));
      if (diff[NIB-1:0] != '0) begin
        k = n + 1;
        break;
      end
    end
  endtask

  // Presents a start for one cycle; returns at the first negedge after the accepting edge.
  task automatic start_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    a_i      = a;
    b_i      = b;
    signed_i = s;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Counts busy negedges from now until done_o is seen, bounded.
  task automatic wait_done(output int nbusy, output logic ok);
    nbusy = 0;
    ok    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      if (busy_o) nbusy++;
      @(negedge clk_i);
    end
  endtask

  task automatic run_and_check(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic s);
    logic [2:0] exp_flags;
    int         k, nbusy;
    logic       ok;
    ref_cmp(a, b, s, exp_flags, k);
    start_cmp(a, b, s);
    wait_done(nbusy, ok);
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(k));
    check({tag, "_flags"}, {29'd0, a_equal_b_o, a_more_b_o, a_less_b_o}, {29'd0, exp_flags});
    @(negedge clk_i);
    check({tag, "_done_one_cycle"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    logic [2:0]       exp_flags;
    logic [2:0]       prev_flags;
    int               k, nbusy, ndone;
    logic             ok;
    logic [WIDTH-1:0] ra, rb, mask;
    logic             rs;
    int               mode, pos;

    rst_i    = 1'b1;
    start_i  = 1'b0;
    signed_i = 1'b0;
    a_i      = '0;
    b_i      = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_flags", {29'd0, a_equal_b_o, a_more_b_o, a_less_b_o}, 32'd0);

    run_and_check("equal", 32'h1234_5678, 32'h1234_5678, 1'b0);
    run_and_check("early", 32'hF000_0000, 32'h1000_0000, 1'b0);
    run_and_check("signed_m1_vs_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    run_and_check("unsigned_m1_vs_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_and_check("signed_min_vs_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    run_and_check("lsb_diff", 32'h0000_0003, 32'h0000_0004, 1'b0);

    // start_i during RUN is ignored; prior flags hold until the new DONE.
    prev_flags = {a_equal_b_o, a_more_b_o, a_less_b_o};
    ref_cmp(32'hABCD_0001, 32'hABCD_0002, 1'b0, exp_flags, k);
    start_cmp(32'hABCD_0001, 32'hABCD_0002, 1'b0);
    a_i     = 32'h9000_0000;
    b_i     = 32'h1000_0000;
    start_i = 1'b1;
    check("ign_flags_hold", {29'd0, a_equal_b_o, a_more_b_o, a_less_b_o}, {29'd0, prev_flags});
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(nbusy, ok);
    check("ign_done_seen", 32'(ok), 32'd1);
    check("ign_busy_cycles", 32'(nbusy + 1), 32'(k));
    check("ign_flags", {29'd0, a_equal_b_o, a_more_b_o, a_less_b_o}, {29'd0, exp_flags});
    ndone = 0;
    repeat (12) begin
      @(negedge clk_i);
      if (done_o) ndone++;
    end
    check("ign_single_done", 32'(ndone), 32'd0);

    // start_i held through DONE starts the next compare with no IDLE cycle.
    start_cmp(32'h0000_0010, 32'h0000_0020, 1'b0);
    start_i = 1'b1;
    wait_done(nbusy, ok);
    check("b2b_first_done", 32'(ok), 32'd1);
    check("b2b_first_flags", {29'd0, a_equal_b_o, a_more_b_o, a_less_b_o}, 32'b001);
    a_i      = 32'h8000_0005;
    b_i      = 32'h0000_0005;
    signed_i = 1'b1;
    ref_cmp(32'h8000_0005, 32'h0000_0005, 1'b1, exp_flags, k);
    @(negedge clk_i);
    start_i = 1'b0;
    check("b2b_no_idle_busy", {31'd0, busy_o}, 32'd1);
    check("b2b_no_idle_done", {31'd0, done_o}, 32'd0);
    wait_done(nbusy, ok);
    check("b2b_second_done", 32'(ok), 32'd1);
    check("b2b_second_busy", 32'(nbusy), 32'(k));
    check("b2b_second_flags", {29'd0, a_equal_b_o, a_more_b_o, a_less_b_o}, {29'd0, exp_flags});
    @(negedge clk_i);

    // Reset during the 3rd RUN cycle of an equal compare.
    start_cmp(32'h5555_AAAA, 32'h5555_AAAA, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    check("midrst_flags", {29'd0, a_equal_b_o, a_more_b_o, a_less_b_o}, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk_i);
      if (done_o || busy_o) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    run_and_check("after_rst", 32'h0F00_0000, 32'h0E00_0000, 1'b1);

    // Randomized compares, biased toward equality and single-nibble differences.
    for (int t = 0; t < 40; t++) begin
      ra   = $urandom;
      rs   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        rb = ra;
      end else if (mode == 1) begin
        rb = $urandom;
      end else begin
        pos  = $urandom_range(0, NNIB - 1);
        mask = {{(WIDTH-NIB){1'b0}}, {NIB{1'b1}}} << (pos * NIB);
        rb   = ra ^ (mask & $urandom);
      end
      run_and_check($sformatf("rand%0d", t), ra, rb, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
